// File: rtl/choose_pkg.sv
// Shared types for the multi-player choose stage and its controller.
// Result encodings are part of the controller-facing contract.
package choose_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CHECK,
    S_CHOOSE,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    CONTINUE = 2'b00,
    LOST     = 2'b01,
    WON      = 2'b10,
    SKIP     = 2'b11
  } result_t;

endpackage

// File: rtl/choose_score_bank.sv
// Per-player score and discard-budget registers.
// One write port addressed by the deciding player, plus a game clear.
module choose_score_bank
  import choose_pkg::*;
#(
  parameter int NUM_PLAYERS  = 2,
  parameter int PLAYER_W     = 1,
  parameter int SCORE_W      = 5,
  parameter int DISC_W       = 2,
  parameter int MAX_DISCARDS = 3
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 clr,
  input  logic                                 wr_en,
  input  logic [PLAYER_W-1:0]                  wr_player,
  input  logic [SCORE_W-1:0]                   wr_score,
  input  logic                                 dec,
  output logic [NUM_PLAYERS-1:0][SCORE_W-1:0]  score_o,
  output logic [NUM_PLAYERS-1:0][DISC_W-1:0]   disc_o
);

  localparam logic [DISC_W-1:0] DISC_INIT = DISC_W'(MAX_DISCARDS);

  logic [NUM_PLAYERS-1:0][SCORE_W-1:0] score_q, score_d;
  logic [NUM_PLAYERS-1:0][DISC_W-1:0]  disc_q, disc_d;

  always_comb begin
    score_d = score_q;
    disc_d  = disc_q;
    if (clr) begin
      score_d = '0;
      disc_d  = {NUM_PLAYERS{DISC_INIT}};
    end else begin
      if (wr_en)
        score_d[wr_player] = wr_score;
      // Never wrap below zero, even if a caller asks.
      if (dec && disc_q[wr_player] != '0)
        disc_d[wr_player] = disc_q[wr_player] - DISC_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      score_q <= '0;
      disc_q  <= {NUM_PLAYERS{DISC_INIT}};
    end else begin
      score_q <= score_d;
      disc_q  <= disc_d;
    end
  end

  assign score_o = score_q;
  assign disc_o  = disc_q;

endmodule

// File: rtl/choose_multi.sv
// Multi-player keep/discard decision engine with discard budget
// and optional decision timeout; one registered result per turn.
module choose_multi
  import choose_pkg::*;
#(
  parameter int NUM_PLAYERS  = 2,
  parameter int TARGET       = 15,
  parameter int DIE_MAX      = 6,
  parameter int FORCE_VAL    = 6,
  parameter int MAX_DISCARDS = 3,
  parameter int TIMEOUT      = 0,
  localparam int PLAYER_W =
    (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1,
  localparam int NUM_W    = $clog2(DIE_MAX + 1),
  localparam int DISC_W   = $clog2(MAX_DISCARDS + 1),
  localparam int SCORE_W  = $clog2(TARGET + DIE_MAX + 1)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           new_game,
  input  logic                           pulse_i,
  input  logic [NUM_W-1:0]               num,
  input  logic                           choice,
  input  logic                           confirm,
  output logic                           pulse_o,
  output logic [1:0]                     result,
  output logic [PLAYER_W-1:0]            player,
  output logic                           game_over,
  output logic [DISC_W-1:0]              discards_left,
  output logic [NUM_PLAYERS*SCORE_W-1:0] scores
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TO_LAST =
    TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [SCORE_W:0] TGT = (SCORE_W+1)'(TARGET);

  state_t  state_q, state_d;
  result_t result_q, result_d, res;

  logic [NUM_W-1:0]    roll_q, roll_d;
  logic [TW-1:0]       cnt_q, cnt_d;
  logic                pulse_q, pulse_d;
  logic                over_q, over_d;
  logic [PLAYER_W-1:0] player_q, player_d, player_nx;
  logic [DISC_W-1:0]   disc_left_q, disc_left_d;

  logic [NUM_PLAYERS-1:0][SCORE_W-1:0] score_arr;
  logic [NUM_PLAYERS-1:0][DISC_W-1:0]  disc_arr;

  logic [SCORE_W-1:0] cur_score, new_score;
  logic [SCORE_W:0]   sum;
  logic do_keep, do_disc, do_skip;
  logic bad_roll, forced, timed_out;
  logic score_we, disc_dec;

  assign cur_score = score_arr[player_q];
  assign sum       = {1'b0, cur_score} + (SCORE_W+1)'(roll_q);
  assign bad_roll  = (roll_q == '0) || (roll_q > NUM_W'(DIE_MAX));
  assign forced    = (roll_q == NUM_W'(FORCE_VAL)) ||
                     (disc_arr[player_q] == '0);
  assign timed_out = (TIMEOUT != 0) && (cnt_q == TO_LAST);
  assign player_nx = (player_q == PLAYER_W'(NUM_PLAYERS - 1)) ?
                     '0 : player_q + PLAYER_W'(1);

  always_comb begin
    state_d   = state_q;
    roll_d    = roll_q;
    cnt_d     = cnt_q;
    pulse_d   = 1'b0;
    result_d  = result_q;
    player_d  = player_q;
    over_d    = over_q;
    do_keep   = 1'b0;
    do_disc   = 1'b0;
    do_skip   = 1'b0;
    res       = CONTINUE;
    new_score = cur_score;

    unique case (state_q)
      S_IDLE: begin
        if (pulse_i) begin
          roll_d  = num;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        unique case (1'b1)
          bad_roll:            do_skip = 1'b1;
          !bad_roll && forced: do_keep = 1'b1;
          default: begin
            state_d = S_CHOOSE;
            cnt_d   = '0;
          end
        endcase
      end
      S_CHOOSE: begin
        cnt_d = cnt_q + TW'(1);
        // An explicit confirm beats a same-cycle expiry.
        unique case (1'b1)
          confirm && choice: do_keep = 1'b1;
          (confirm && !choice) || (!confirm && timed_out):
            do_disc = 1'b1;
          default: ;
        endcase
      end
      S_DONE: ;
      default: state_d = S_IDLE;
    endcase

    if (do_keep) begin
      unique case (1'b1)
        sum > TGT: begin
          res       = LOST;
          new_score = sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
        end
        sum == TGT: begin
          res       = WON;
          new_score = SCORE_W'(TARGET);
        end
        default: new_score = sum[SCORE_W-1:0];
      endcase
    end
    if (do_disc || do_skip)
      res = SKIP;

    if (do_keep || do_disc || do_skip) begin
      pulse_d  = 1'b1;
      result_d = res;
      if (res == WON || res == LOST) begin
        state_d = S_DONE;
        over_d  = 1'b1;
      end else begin
        state_d  = S_IDLE;
        player_d = player_nx;
      end
    end

    if (new_game) begin
      state_d  = S_IDLE;
      pulse_d  = 1'b0;
      result_d = CONTINUE;
      player_d = '0;
      over_d   = 1'b0;
    end
  end

  assign score_we = do_keep && !new_game;
  assign disc_dec = do_disc && !new_game;

  // Show the incoming player's budget, including this turn's debit.
  always_comb begin
    disc_left_d = disc_arr[player_d];
    if (disc_dec && player_d == player_q)
      disc_left_d = disc_left_d - DISC_W'(1);
    if (new_game)
      disc_left_d = DISC_W'(MAX_DISCARDS);
  end

  choose_score_bank #(
    .NUM_PLAYERS  (NUM_PLAYERS),
    .PLAYER_W     (PLAYER_W),
    .SCORE_W      (SCORE_W),
    .DISC_W       (DISC_W),
    .MAX_DISCARDS (MAX_DISCARDS)
  ) u_bank (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (new_game),
    .wr_en     (score_we),
    .wr_player (player_q),
    .wr_score  (new_score),
    .dec       (disc_dec),
    .score_o   (score_arr),
    .disc_o    (disc_arr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      result_q    <= CONTINUE;
      roll_q      <= '0;
      cnt_q       <= '0;
      pulse_q     <= 1'b0;
      over_q      <= 1'b0;
      player_q    <= '0;
      disc_left_q <= DISC_W'(MAX_DISCARDS);
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      roll_q      <= roll_d;
      cnt_q       <= cnt_d;
      pulse_q     <= pulse_d;
      over_q      <= over_d;
      player_q    <= player_d;
      disc_left_q <= disc_left_d;
    end
  end

  assign pulse_o       = pulse_q;
  assign result        = result_q;
  assign player        = player_q;
  assign game_over     = over_q;
  assign discards_left = disc_left_q;
  assign scores        = score_arr;

endmodule

// File: tb/tb_choose_multi.sv
// Directed bench for choose_multi: a 2-player default instance
// and a 3-player instance with an 8-cycle decision timeout.
module tb_choose_multi;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: defaults
  logic       a_rst_n, a_ng, a_pulse, a_choice, a_confirm;
  logic [2:0] a_num;
  logic       a_pulse_o, a_over;
  logic [1:0] a_result, a_dl;
  logic [0:0] a_player;
  logic [9:0] a_scores;

  choose_multi u_a (
    .clk           (clk),
    .rst_n         (a_rst_n),
    .new_game      (a_ng),
    .pulse_i       (a_pulse),
    .num           (a_num),
    .choice        (a_choice),
    .confirm       (a_confirm),
    .pulse_o       (a_pulse_o),
    .result        (a_result),
    .player        (a_player),
    .game_over     (a_over),
    .discards_left (a_dl),
    .scores        (a_scores)
  );

  // Instance B: 3 players, TIMEOUT=8
  logic        b_rst_n, b_ng, b_pulse, b_choice, b_confirm;
  logic [2:0]  b_num;
  logic        b_pulse_o, b_over;
  logic [1:0]  b_result, b_dl;
  logic [1:0]  b_player;
  logic [14:0] b_scores;

  choose_multi #(
    .NUM_PLAYERS (3),
    .TIMEOUT     (8)
  ) u_b (
    .clk           (clk),
    .rst_n         (b_rst_n),
    .new_game      (b_ng),
    .pulse_i       (b_pulse),
    .num           (b_num),
    .choice        (b_choice),
    .confirm       (b_confirm),
    .pulse_o       (b_pulse_o),
    .result        (b_result),
    .player        (b_player),
    .game_over     (b_over),
    .discards_left (b_dl),
    .scores        (b_scores)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp)
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    else
      n_pass++;
  endtask

  typedef struct {
    logic       ng;
    logic [2:0] num;
    logic       conf;
    logic       choice;
    logic [1:0] res;
    logic [0:0] plyr;
    logic [9:0] sc;
    logic [1:0] dl;
    logic       over;
  } vec_t;

  vec_t vt[19];

  task automatic a_new_game();
    a_ng    = 1'b1;
    a_pulse = 1'b1;
    a_num   = 3'd6;
    @(negedge clk);
    a_ng    = 1'b0;
    a_pulse = 1'b0;
    chk("ng_pulse", 32'(a_pulse_o), 0);
    chk("ng_scores", 32'(a_scores), 0);
    chk("ng_player", 32'(a_player), 0);
    chk("ng_dl", 32'(a_dl), 3);
    chk("ng_result", 32'(a_result), 0);
    chk("ng_over", 32'(a_over), 0);
    @(negedge clk);
    chk("ng_drop_pulse", 32'(a_pulse_o), 0);
  endtask

  // Entered and left on a falling edge; the next turn's pulse_i
  // is therefore applied while pulse_o is still high.
  task automatic run_vec(input int i);
    if (vt[i].ng)
      a_new_game();
    a_pulse = 1'b1;
    a_num   = vt[i].num;
    @(negedge clk);
    a_pulse = 1'b0;
    chk($sformatf("v%0d_lat1", i), 32'(a_pulse_o), 0);
    @(negedge clk);
    if (vt[i].conf) begin
      chk($sformatf("v%0d_wait", i), 32'(a_pulse_o), 0);
      a_confirm = 1'b1;
      a_choice  = vt[i].choice;
      @(negedge clk);
      a_confirm = 1'b0;
      a_choice  = 1'b0;
    end
    chk($sformatf("v%0d_pulse", i), 32'(a_pulse_o), 1);
    chk($sformatf("v%0d_result", i), 32'(a_result), 32'(vt[i].res));
    chk($sformatf("v%0d_player", i), 32'(a_player), 32'(vt[i].plyr));
    chk($sformatf("v%0d_scores", i), 32'(a_scores), 32'(vt[i].sc));
    chk($sformatf("v%0d_dl", i), 32'(a_dl), 32'(vt[i].dl));
    chk($sformatf("v%0d_over", i), 32'(a_over), 32'(vt[i].over));
  endtask

  task automatic b_forced(input logic [2:0] n, input logic [1:0] pl,
                          input logic [1:0] dl, input string nm);
    b_pulse = 1'b1;
    b_num   = n;
    @(negedge clk);
    b_pulse = 1'b0;
    @(negedge clk);
    chk({nm, "_pulse"}, 32'(b_pulse_o), 1);
    chk({nm, "_player"}, 32'(b_player), 32'(pl));
    chk({nm, "_dl"}, 32'(b_dl), 32'(dl));
  endtask

  initial begin
    logic seen;

    //        ng   num  cf  ch  res  pl  scores  dl  over
    vt[0]  = '{1'b0, 3'd6, 1'b0, 1'b0, 2'd0, 1'd1, 10'd6,   2'd3, 1'b0};
    vt[1]  = '{1'b0, 3'd3, 1'b1, 1'b1, 2'd0, 1'd0, 10'd102, 2'd3, 1'b0};
    vt[2]  = '{1'b0, 3'd4, 1'b1, 1'b1, 2'd0, 1'd1, 10'd106, 2'd3, 1'b0};
    vt[3]  = '{1'b0, 3'd5, 1'b1, 1'b0, 2'd3, 1'd0, 10'd106, 2'd3, 1'b0};
    vt[4]  = '{1'b0, 3'd5, 1'b1, 1'b1, 2'd2, 1'd0, 10'd111, 2'd3, 1'b1};
    vt[5]  = '{1'b1, 3'd6, 1'b0, 1'b0, 2'd0, 1'd1, 10'd6,   2'd3, 1'b0};
    vt[6]  = '{1'b0, 3'd6, 1'b0, 1'b0, 2'd0, 1'd0, 10'd198, 2'd3, 1'b0};
    vt[7]  = '{1'b0, 3'd0, 1'b0, 1'b0, 2'd3, 1'd1, 10'd198, 2'd3, 1'b0};
    vt[8]  = '{1'b0, 3'd6, 1'b0, 1'b0, 2'd0, 1'd0, 10'd390, 2'd3, 1'b0};
    vt[9]  = '{1'b0, 3'd7, 1'b0, 1'b0, 2'd3, 1'd1, 10'd390, 2'd3, 1'b0};
    vt[10] = '{1'b0, 3'd4, 1'b1, 1'b1, 2'd1, 1'd1, 10'd518, 2'd3, 1'b1};
    vt[11] = '{1'b1, 3'd2, 1'b1, 1'b0, 2'd3, 1'd1, 10'd0,   2'd3, 1'b0};
    vt[12] = '{1'b0, 3'd0, 1'b0, 1'b0, 2'd3, 1'd0, 10'd0,   2'd2, 1'b0};
    vt[13] = '{1'b0, 3'd2, 1'b1, 1'b0, 2'd3, 1'd1, 10'd0,   2'd3, 1'b0};
    vt[14] = '{1'b0, 3'd0, 1'b0, 1'b0, 2'd3, 1'd0, 10'd0,   2'd1, 1'b0};
    vt[15] = '{1'b0, 3'd2, 1'b1, 1'b0, 2'd3, 1'd1, 10'd0,   2'd3, 1'b0};
    vt[16] = '{1'b0, 3'd0, 1'b0, 1'b0, 2'd3, 1'd0, 10'd0,   2'd0, 1'b0};
    vt[17] = '{1'b0, 3'd2, 1'b0, 1'b0, 2'd0, 1'd1, 10'd2,   2'd3, 1'b0};
    vt[18] = '{1'b0, 3'd0, 1'b0, 1'b0, 2'd3, 1'd0, 10'd2,   2'd0, 1'b0};

    a_rst_n = 1'b0; a_ng = 1'b0; a_pulse = 1'b0;
    a_num = '0; a_choice = 1'b0; a_confirm = 1'b0;
    b_rst_n = 1'b0; b_ng = 1'b0; b_pulse = 1'b0;
    b_num = '0; b_choice = 1'b0; b_confirm = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_a_pulse", 32'(a_pulse_o), 0);
    chk("rst_a_result", 32'(a_result), 0);
    chk("rst_a_player", 32'(a_player), 0);
    chk("rst_a_over", 32'(a_over), 0);
    chk("rst_a_scores", 32'(a_scores), 0);
    chk("rst_a_dl", 32'(a_dl), 3);
    chk("rst_b_scores", 32'(b_scores), 0);
    chk("rst_b_dl", 32'(b_dl), 3);
    a_rst_n = 1'b1;
    b_rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++)
      run_vec(i);

    // Finished game: rolls and confirms are ignored
    seen    = 1'b0;
    a_pulse = 1'b1;
    a_num   = 3'd6;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      a_pulse   = 1'b0;
      a_confirm = (k == 1);
      a_choice  = 1'b1;
      if (a_pulse_o) seen = 1'b1;
    end
    a_confirm = 1'b0;
    a_choice  = 1'b0;
    chk("done_no_pulse", 32'(seen), 0);
    chk("done_scores", 32'(a_scores), 111);
    chk("done_over", 32'(a_over), 1);

    for (int i = 5; i < 19; i++)
      run_vec(i);

    // Timeout: CHOOSE entered 2 cycles after pulse_i, SKIP 8 later
    seen    = 1'b0;
    b_pulse = 1'b1;
    b_num   = 3'd2;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      b_pulse = 1'b0;
      if (b_pulse_o) seen = 1'b1;
    end
    chk("to_early", 32'(seen), 0);
    @(negedge clk);
    chk("to_pulse", 32'(b_pulse_o), 1);
    chk("to_result", 32'(b_result), 3);
    chk("to_player", 32'(b_player), 1);
    chk("to_scores", 32'(b_scores), 0);

    b_forced(3'd6, 2'd2, 2'd3, "b_p1");
    b_forced(3'd6, 2'd0, 2'd2, "b_wrap");
    chk("b_wrap_scores", 32'(b_scores), 6336);

    // Confirm in the expiry cycle takes precedence
    seen    = 1'b0;
    b_pulse = 1'b1;
    b_num   = 3'd3;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      b_pulse = 1'b0;
      if (b_pulse_o) seen = 1'b1;
      if (k == 9) begin
        b_confirm = 1'b1;
        b_choice  = 1'b1;
      end
    end
    chk("tc_early", 32'(seen), 0);
    @(negedge clk);
    b_confirm = 1'b0;
    b_choice  = 1'b0;
    chk("tc_pulse", 32'(b_pulse_o), 1);
    chk("tc_result", 32'(b_result), 0);
    chk("tc_scores", 32'(b_scores), 6339);
    chk("tc_player", 32'(b_player), 1);

    // Asynchronous reset while in CHOOSE
    b_pulse = 1'b1;
    b_num   = 3'd2;
    @(negedge clk);
    b_pulse = 1'b0;
    @(negedge clk);
    b_rst_n = 1'b0;
    #1;
    chk("ar_pulse", 32'(b_pulse_o), 0);
    chk("ar_result", 32'(b_result), 0);
    chk("ar_player", 32'(b_player), 0);
    chk("ar_over", 32'(b_over), 0);
    chk("ar_scores", 32'(b_scores), 0);
    chk("ar_dl", 32'(b_dl), 3);
    @(negedge clk);
    b_rst_n = 1'b1;
    @(negedge clk);
    b_confirm = 1'b1;
    b_choice  = 1'b1;
    @(negedge clk);
    b_confirm = 1'b0;
    b_choice  = 1'b0;
    chk("ar_idle", 32'(b_pulse_o), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/choose_multi.md
# choose_multi

Parametrised keep/discard decision engine for the dice game, the successor to the single-player choose stage. After each roll it tracks per-player scores, forces a keep on the forced value, and takes keep/discard input from the current player, with a per-player discard budget and an optional decision timeout. It sits between the roller and the game controller: it takes the roll pulse from the roller and returns one registered result pulse per turn to the controller.

## Interface
- `NUM_PLAYERS`, 2: players, range 1..8; `PLAYER_W = max(1,$clog2(NUM_PLAYERS))`.
- `TARGET`, 15: exact winning score.
- `DIE_MAX`, 6: highest legal roll; `NUM_W = $clog2(DIE_MAX+1)`.
- `FORCE_VAL`, 6: roll that is always kept, in 1..DIE_MAX.
- `MAX_DISCARDS`, 3: discards allowed per player per game; `DISC_W = $clog2(MAX_DISCARDS+1)`.
- `TIMEOUT`, 0: cycles allowed in CHOOSE before an automatic discard; 0 disables the timeout.
- `SCORE_W = $clog2(TARGET+DIE_MAX+1)`: derived, not overridable.
- `clk` in 1: the only clock; all logic is rising-edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `new_game` in 1: synchronous clear; takes priority over every other input.
- `pulse_i` in 1: roll valid.
- `num` in NUM_W: roll value, sampled only with `pulse_i`.
- `choice` in 1: 1 = keep, 0 = discard.
- `confirm` in 1: single-cycle pulse, debounced upstream.
- `pulse_o` out 1: one-cycle turn-complete pulse.
- `result` out 2: 00 CONTINUE, 01 LOST, 10 WON, 11 SKIP; valid with `pulse_o` and held until the next pulse.
- `player` out PLAYER_W: player whose turn it is, i.e. who is deciding.
- `game_over` out 1: high from a WON/LOST pulse until `new_game`.
- `discards_left` out DISC_W: remaining discards for `player`.
- `scores` out NUM_PLAYERS*SCORE_W: packed scores, player 0 in the LSBs.

## Operation
- States:
  - IDLE: waiting for a roll.
  - CHECK: classify the latched roll.
  - CHOOSE: waiting for the player's decision.
  - DONE: game finished.
- IDLE: on `pulse_i`, latch `num` into `roll_q` and go to CHECK. `pulse_i` is ignored in every other state.
- CHECK, first matching rule applies:
  - `roll_q==0` or `roll_q>DIE_MAX`: resolve SKIP. No discard is consumed.
  - `roll_q==FORCE_VAL` or the player's discard count is 0: resolve KEEP.
  - Otherwise: go to CHOOSE and clear the timeout counter.
- CHOOSE:
  - `confirm&&choice`: resolve KEEP.
  - `confirm&&!choice`: resolve DISCARD.
  - TIMEOUT!=0 and the counter reaches TIMEOUT-1 with no `confirm`: resolve DISCARD.
  - `choice` is sampled only in the cycle `confirm` is high.
- Resolve KEEP:
  - `sum = score[player] + roll_q`, computed at SCORE_W+1 bits, with no wrap.
  - `sum>TARGET`: LOST; the player's score is set to `sum` (saturating at the all-ones value if wider).
  - `sum==TARGET`: WON; the player's score is set to TARGET.
  - Otherwise: CONTINUE; the player's score is set to `sum`.
- Resolve DISCARD: decrement the player's discard count; result SKIP; score unchanged.
- After CONTINUE or SKIP: `player` advances, wrapping from NUM_PLAYERS-1 to 0; return to IDLE.
- After WON or LOST: go to DONE; `player` holds the deciding player.
- DONE: all inputs except `new_game` are ignored.
- `new_game`, in any state:
  - All scores go to 0.
  - All discard counts go to MAX_DISCARDS.
  - `player` goes to 0; `game_over` goes to 0; `result` goes to CONTINUE; state goes to IDLE.
  - `pulse_o` does not fire.
  - A `pulse_i` in the same cycle is dropped.

## Timing
- Reset values: state IDLE; `pulse_o` 0; `result` 00; `player` 0; `game_over` 0; `scores` 0; `discards_left` MAX_DISCARDS. Reset applies immediately and asynchronously, including mid-turn.
- All outputs are registered.
- Forced or skip path: `pulse_i` at cycle t, CHECK at t+1, `pulse_o`/`result`/`scores` updated at t+2.
- Choice path: `confirm` at cycle c, outputs at c+1.
- Timeout path: CHOOSE entered at cycle e; auto-discard `pulse_o` at e+TIMEOUT.
- `player` and `discards_left` update in the same cycle `pulse_o` rises.
- Throughput: one turn per 2 cycles minimum. A `pulse_i` arriving while `pulse_o` is high is accepted (state is IDLE).
- `confirm` arriving in the same cycle the timeout expires: `confirm` wins.

## Structure
- `choose_pkg` holds:
  - the `state_t` and `result_t` enums;
  - the `CONTINUE`, `LOST`, `WON` and `SKIP` encodings, shared with the controller.
- Sub-module `choose_score_bank`: per-player score and discard-count registers, with a write port (player, new score, decrement flag) and a clear input. The FSM, timeout counter and resolve arithmetic stay in the top level.

## Test plan
- Defaults; score 0, roll 6 -> forced keep: `pulse_o` 2 cycles after `pulse_i`, CONTINUE, `scores[0]`=6, `player`=1.
- Player 0 at 10, roll 5, `choice=1` + `confirm` -> WON, score 15, `game_over`=1; a later `pulse_i` produces no `pulse_o`.
- Player 1 at 12, roll 4, keep -> LOST, score 16; `new_game` -> all scores 0, `player` 0, `discards_left` 3.
- Player 0 makes three discards; fourth roll of 2 -> kept without entering CHOOSE, score +2, `discards_left` stays 0.
- TIMEOUT=8, no `confirm` -> SKIP pulse exactly 8 cycles after CHOOSE entry, `discards_left` 3->2. Separately, `confirm` on the expiry cycle -> the `confirm` decision is taken.
- `num`=7 -> SKIP with no discard consumed. NUM_PLAYERS=3: `player` wraps 2->0. `rst_n` low during CHOOSE -> all outputs return to reset values.
